// File: rtl/fifo_rd_ptr_empty.sv
// Read-side pointer and EMPTY flag generator for the async FIFO (Gray pointer out, registered EMPTY).
// Optional FIFO_RD_LEVEL_EN adds a registered occupancy output (rlevel) as seen by the reader.
module fifo_rd_ptr_empty #(
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rinc,
  input  logic [ADDR_WIDTH:0]   sync_wptr,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic [ADDR_WIDTH:0]   rptr,
  output logic                  empty
`ifdef FIFO_RD_LEVEL_EN
  ,
  output logic [ADDR_WIDTH:0]   rlevel
`endif
);

  logic [ADDR_WIDTH:0] rbin_reg;
  logic [ADDR_WIDTH:0] rbin_next;
  logic [ADDR_WIDTH:0] rgray_next;
  logic [ADDR_WIDTH:0] rptr_reg;
  logic                empty_reg;
  logic                rinc_ok;

  assign rinc_ok    = rinc & ~empty_reg;
  assign rbin_next  = rbin_reg + {{ADDR_WIDTH{1'b0}}, rinc_ok};
  assign rgray_next = (rbin_next >> 1) ^ rbin_next;

  // Compare against the next pointer so EMPTY rises on the edge that consumes the last word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rbin_reg  <= '0;
      rptr_reg  <= '0;
      empty_reg <= 1'b1;
    end else begin
      rbin_reg  <= rbin_next;
      rptr_reg  <= rgray_next;
      empty_reg <= (rgray_next == sync_wptr);
    end
  end

  assign raddr = rbin_reg[ADDR_WIDTH-1:0];
  assign rptr  = rptr_reg;
  assign empty = empty_reg;

`ifdef FIFO_RD_LEVEL_EN
  logic [ADDR_WIDTH:0] wbin_s;
  logic [ADDR_WIDTH:0] rlevel_reg;

  // Gray-to-binary: each bit is the XOR of all Gray bits at and above it.
  for (genvar gi = 0; gi <= ADDR_WIDTH; gi++) begin : g_gray2bin
    assign wbin_s[gi] = ^sync_wptr[ADDR_WIDTH:gi];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rlevel_reg <= '0;
    end else begin
      rlevel_reg <= wbin_s - rbin_next;
    end
  end

  assign rlevel = rlevel_reg;
`endif

endmodule
